pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_pkg.sv | 16 +
 rtl/pwm_capture_sync2.sv | 25 ++
 rtl/pwm_capture.sv | 129 ++++++++++++
 tb/tb_pwm_capture.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block.
package pwm_pkg;

  // Default counter width, sized to the generator's 16-bit High/Low loads.
  localparam int PWM_CNT_W = 16;

  // Saturation value for the default counter width.
  localparam logic [PWM_CNT_W-1:0] PWM_CNT_SAT = '1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_capture_sync2.sv
// Two-flop synchroniser for a single asynchronous input.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/pwm_capture.sv
// Measures high/low phase lengths of an asynchronous PWM input in clk cycles.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W = PWM_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  input  logic             clear,
  output logic [CNT_W-1:0] high_width,
  output logic [CNT_W-1:0] low_width,
  output logic             valid,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  logic             w_s;
  logic             r_s_d;
  logic             w_rise;
  logic             w_fall;
  logic             w_edge;
  pwm_state_e       r_state;
  pwm_state_e       w_state_nxt;
  logic             w_latch_high;
  logic             w_capture;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_high_hold;
  logic [CNT_W-1:0] r_high_w;
  logic [CNT_W-1:0] r_low_w;
  logic             r_valid;
  logic             r_ovf;

  sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pwm_in),
    .q     (w_s)
  );

  // Delayed copy of the synchronised level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_s_d <= 1'b0;
    else        r_s_d <= w_s;
  end

  assign w_rise = w_s & ~r_s_d;
  assign w_fall = ~w_s & r_s_d;
  assign w_edge = w_s ^ r_s_d;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state plus the latch/capture strobes; clear beats any edge.
  always_comb begin
    w_state_nxt  = r_state;
    w_latch_high = 1'b0;
    w_capture    = 1'b0;
    if (clear) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rise) w_state_nxt = MEAS_HIGH;
        end
        MEAS_HIGH: begin
          if (w_fall) begin
            w_state_nxt  = MEAS_LOW;
            w_latch_high = 1'b1;
          end
        end
        MEAS_LOW: begin
          if (w_rise) begin
            w_state_nxt = MEAS_HIGH;
            w_capture   = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Phase counter: reload 1 on any edge so it equals the ended phase length at the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_cnt <= '0;
    else if (clear)            r_cnt <= '0;
    else if (w_edge)           r_cnt <= CNT_W'(1);
    else if (r_cnt != CNT_SAT) r_cnt <= r_cnt + CNT_W'(1);
  end

  // High phase held until the closing rise publishes both widths together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_high_hold <= '0;
      r_high_w    <= '0;
      r_low_w     <= '0;
      r_valid     <= 1'b0;
    end else if (clear) begin
      r_high_hold <= '0;
      r_high_w    <= '0;
      r_low_w     <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_valid <= w_capture;
      if (w_latch_high) r_high_hold <= r_cnt;
      if (w_capture) begin
        r_high_w <= r_high_hold;
        r_low_w  <= r_cnt;
      end
    end
  end

  // Sticky overflow; saturation while waiting in IDLE is not a measurement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    r_ovf <= 1'b0;
    else if (clear)                                r_ovf <= 1'b0;
    else if (r_state != IDLE && r_cnt == CNT_SAT)  r_ovf <= 1'b1;
  end

  assign high_width = r_high_w;
  assign low_width  = r_low_w;
  assign valid      = r_valid;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: run-length reference model, table-driven PWM configs, directed corners.
module tb_pwm_capture;

  localparam int SAT = 65535;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm_in = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] high_width;
  logic [15:0] low_width;
  logic        valid;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  pwm_capture #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .clear      (clear),
    .high_width (high_width),
    .low_width  (low_width),
    .valid      (valid),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  // Stimulus generator: 0 = constant level, 1 = PWM (period latched at each rise), 2 = random bits.
  int   gen_mode = 0;
  logic gen_level = 1'b0;
  int   cfg_hi = 3, cfg_lo = 5, cur_hi = 3, cur_lo = 5, ph_left = 0;

  always @(negedge clk) begin
    case (gen_mode)
      0: pwm_in = gen_level;
      2: pwm_in = 1'($urandom_range(0, 1));
      default: begin
        ph_left--;
        if (ph_left <= 0) begin
          if (pwm_in) begin
            pwm_in  = 1'b0;
            ph_left = cur_lo;
          end else begin
            cur_hi  = cfg_hi;
            cur_lo  = cfg_lo;
            pwm_in  = 1'b1;
            ph_left = cur_hi;
          end
        end
      end
    endcase
  end

  // Reference model: run lengths of the sampled input, reported two edges later.
  typedef struct {
    bit v;
    int hw;
    int lw;
    bit ovf;
    bit skip;
  } exp_t;

  exp_t p0, p1, cur;
  logic m_lvl;
  int   m_run, m_hi, m_hw, m_lw;
  bit   m_meas, m_hiok, m_ovf, m_v;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_lvl = 1'b0; m_run = 0; m_hi = 0; m_hw = 0; m_lw = 0;
      m_meas = 0; m_hiok = 0; m_ovf = 0; m_v = 0;
      p0 = '{0, 0, 0, 0, 0}; p1 = p0; cur = p0;
    end else begin
      m_v = 0;
      if (pwm_in != m_lvl) begin
        if (pwm_in) begin
          if (m_meas && m_hiok) begin
            m_v  = 1;
            m_hw = m_hi;
            m_lw = sat(m_run);
          end
          m_meas = 1;
          m_hiok = 0;
        end else if (m_meas) begin
          m_hi   = sat(m_run);
          m_hiok = 1;
        end
        m_lvl = pwm_in;
        m_run = 1;
      end else if (m_run < 1000000) begin
        m_run++;
      end
      if (m_meas && m_run >= SAT + 1) m_ovf = 1;
      cur = p1;
      p1  = p0;
      p0  = '{m_v, m_hw, m_lw, m_ovf, (m_meas && m_run >= SAT - 8 && m_run <= SAT + 10)};
    end
  end

  // Per-cycle scoreboard against the model.
  bit sb_en = 0;
  always @(negedge clk) begin
    if (sb_en && rst_n) begin
      chk("sb_valid", int'(valid), int'(cur.v));
      chk("sb_high_width", int'(high_width), cur.hw);
      chk("sb_low_width", int'(low_width), cur.lw);
      if (!cur.skip) chk("sb_ovf", int'(ovf), int'(cur.ovf));
    end
  end

  int n_valid = 0;
  always @(negedge clk) if (rst_n && valid) n_valid++;

  initial begin
    #(98000 * 10);
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic hold(input logic lvl, input int n);
    gen_level = lvl;
    repeat (n) @(posedge clk);
  endtask

  typedef struct {
    int hi;
    int lo;
    int ehw;
    int elw;
  } row_t;

  row_t tbl[5];
  int   n0, cyc, k, rh, rl;

  initial begin
    tbl[0] = '{3, 5, 3, 5};
    tbl[1] = '{1, 1, 1, 1};
    tbl[2] = '{10, 2, 10, 2};
    tbl[3] = '{2, 7, 2, 7};
    tbl[4] = '{1, 4, 1, 4};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(valid), 0);
    chk("rst_high_width", int'(high_width), 0);
    chk("rst_low_width", int'(low_width), 0);
    chk("rst_ovf", int'(ovf), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("idle_low_no_valid", n_valid, 0);
    sb_en = 1;

    // Latency: valid on the 2nd edge after the first flop samples the closing rise
    @(posedge clk);
    hold(1'b0, 6);
    hold(1'b1, 3);
    hold(1'b0, 5);
    gen_level = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 chk("lat_edge1_valid", int'(valid), 0);
    @(posedge clk);
    #1;
    chk("lat_edge2_valid", int'(valid), 1);
    chk("lat_high_width", int'(high_width), 3);
    chk("lat_low_width", int'(low_width), 5);

    // Table of generator settings, reprogrammed on the fly
    for (int i = 0; i < 5; i++) begin
      cfg_hi   = tbl[i].hi;
      cfg_lo   = tbl[i].lo;
      gen_mode = 1;
      repeat (40) @(posedge clk);
      n0 = n_valid;
      repeat (10 * (tbl[i].hi + tbl[i].lo)) @(posedge clk);
      #1;
      chk("tbl_valid_count", n_valid - n0, 10);
      chk("tbl_high_width", int'(high_width), tbl[i].ehw);
      chk("tbl_low_width", int'(low_width), tbl[i].elw);
      chk("tbl_ovf", int'(ovf), 0);
    end

    // Random bit stream, then random PWM settings
    gen_mode = 2;
    repeat (1500) @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      rh = $urandom_range(1, 12);
      rl = $urandom_range(1, 12);
      cfg_hi   = rh;
      cfg_lo   = rl;
      gen_mode = 1;
      repeat (80 + $urandom_range(0, 40)) @(posedge clk);
      #1;
      chk("rnd_high_width", int'(high_width), rh);
      chk("rnd_low_width", int'(low_width), rl);
    end

    // Reset pulsed mid high phase
    cfg_hi = 3;
    cfg_lo = 5;
    repeat (50) @(posedge clk);
    k = 0;
    while (pwm_in !== 1'b1 && k < 20) begin @(posedge clk); k++; end
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_valid", int'(valid), 0);
    chk("rstmid_high_width", int'(high_width), 0);
    chk("rstmid_low_width", int'(low_width), 0);
    chk("rstmid_ovf", int'(ovf), 0);
    repeat (3) @(posedge clk);
    k = 0;
    while (pwm_in !== 1'b0 && k < 20) begin @(posedge clk); k++; end
    n0 = n_valid;
    @(negedge clk) rst_n = 1'b1;
    cyc = 0;
    while (n_valid == n0 && cyc < 40) begin @(posedge clk); cyc++; end
    #1;
    chk("rstmid_valid_in_time", int'(cyc < 40), 1);
    chk("rstmid_full_period_first", int'(cyc >= 10), 1);
    chk("rstmid_high_width_after", int'(high_width), 3);
    chk("rstmid_low_width_after", int'(low_width), 5);

    // Clear in the same cycle as a rise in MEAS_LOW
    sb_en    = 0;
    gen_mode = 0;
    @(posedge clk);
    hold(1'b0, 6);
    hold(1'b1, 3);
    hold(1'b0, 5);
    n0 = n_valid;
    gen_level = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_no_valid", int'(valid), 0);
    chk("clr_high_width", int'(high_width), 0);
    chk("clr_low_width", int'(low_width), 0);
    clear = 1'b0;
    hold(1'b1, 2);
    hold(1'b0, 5);
    hold(1'b1, 3);
    hold(1'b0, 4);
    #1 chk("clr_idle_no_valid", n_valid - n0, 0);
    hold(1'b1, 4);
    #1;
    chk("clr_next_valid", n_valid - n0, 1);
    chk("clr_next_high", int'(high_width), 3);
    chk("clr_next_low", int'(low_width), 4);

    // Long high phase: saturation and sticky ovf
    gen_level = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    sb_en = 1;
    @(posedge clk);
    hold(1'b0, 4);
    hold(1'b1, 60000);
    #1 chk("ovf_before_sat", int'(ovf), 0);
    hold(1'b1, 10000);
    #1;
    chk("ovf_after_sat", int'(ovf), 1);
    chk("ovf_no_valid_const", int'(valid), 0);
    hold(1'b0, 5);
    hold(1'b1, 3);
    #1;
    chk("ovf_high_width_sat", int'(high_width), SAT);
    chk("ovf_low_width", int'(low_width), 5);
    chk("ovf_sticky", int'(ovf), 1);
    sb_en = 0;
    clear = 1'b1;
    @(posedge clk);
    #1;
    chk("ovf_cleared", int'(ovf), 0);
    chk("ovf_clear_high_width", int'(high_width), 0);
    clear = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
